// File: rtl/vga_pkg.sv
// vga_pkg: 640x480 @ 60 Hz raster constants and the shared coordinate type.
// Optional feature macro used by vga_timing_gen: VGA_TIMING_FRAME_CNT_EN.
package vga_pkg;

    // Horizontal timing, in pixels.
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;

    // Vertical timing, in lines.
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VISIBLE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_VISIBLE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrap counter for one raster axis. Counts 0..Total-1 when enabled,
// resets to Total-1 so the first enabled edge lands on 0. Exposes the next value so the
// parent can decode registered outputs that line up with the counter itself.
module vga_axis_counter
#(
    parameter int unsigned Total = 800
) (
    input  logic            vga_clk,
    input  logic            reset_n,
    input  logic            en,
    output vga_pkg::coord_t count,
    output vga_pkg::coord_t count_next,
    output logic            wrap
);
    import vga_pkg::*;

    localparam coord_t Last = coord_t'(Total - 1);

    // Next-value and wrap decode from the current count.
    always_comb begin
        wrap       = en && (count == Last);
        count_next = count;
        if (en) begin
            count_next = wrap ? '0 : count + 10'd1;
        end
    end

    // Counter register; reset parks it on the last position of the axis.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= Last;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing from the pixel clock. Owns the X/Y counters and drives
// registered blank (1 = visible), active-low hs/vs, frame_start and frame_cnt.
// Macro VGA_TIMING_FRAME_CNT_EN: when defined, frame_cnt counts frame_start cycles
// (wrapping at 256); otherwise frame_cnt is tied to zero and no counter flops exist.
module vga_timing_gen
#(
    parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int unsigned H_FP      = vga_pkg::H_FP,
    parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
    parameter int unsigned H_BP      = vga_pkg::H_BP,
    parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int unsigned V_FP      = vga_pkg::V_FP,
    parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
    parameter int unsigned V_BP      = vga_pkg::V_BP
) (
    input  logic            vga_clk,
    input  logic            reset_n,
    output vga_pkg::coord_t DrawX,
    output vga_pkg::coord_t DrawY,
    output logic            blank,
    output logic            hs,
    output logic            vs,
    output logic            frame_start,
    output logic [7:0]      frame_cnt
);
    import vga_pkg::*;

    localparam int unsigned HTotal  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam coord_t      HVis    = coord_t'(H_VISIBLE);
    localparam coord_t      VVis    = coord_t'(V_VISIBLE);
    localparam coord_t      HsStart = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t      HsEnd   = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam coord_t      VsStart = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t      VsEnd   = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    coord_t x_next;
    coord_t y_next;
    logic   h_wrap;
    logic   v_wrap;
    logic   blank_d;
    logic   hs_d;
    logic   vs_d;

    vga_axis_counter #(
        .Total (HTotal)
    ) u_h_cnt (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .en         (1'b1),
        .count      (DrawX),
        .count_next (x_next),
        .wrap       (h_wrap)
    );

    vga_axis_counter #(
        .Total (VTotal)
    ) u_v_cnt (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .en         (h_wrap),
        .count      (DrawY),
        .count_next (y_next),
        .wrap       (v_wrap)
    );

    // Decode flags from the next counter values so they register alongside DrawX/DrawY.
    always_comb begin
        blank_d = (x_next < HVis) && (y_next < VVis);
        hs_d    = !((x_next >= HsStart) && (x_next <= HsEnd));
        vs_d    = !((y_next >= VsStart) && (y_next <= VsEnd));
    end

    // Registered outputs; the vertical wrap is exactly the step into (0, 0).
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            blank       <= 1'b0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            blank       <= blank_d;
            hs          <= hs_d;
            vs          <= vs_d;
            frame_start <= v_wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    // Count frame_start cycles; the increment shows on the cycle after the pulse.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= 8'd0;
        end else if (frame_start) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance plus a shrunken-geometry instance (so whole
// frames and the frame counter wrap fit in a short run), random reset timing, and a
// scoreboard fed by an arithmetic raster model.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_FRAME_CNT_EN
    localparam bit FcEn = 1'b1;
`else
    localparam bit FcEn = 1'b0;
`endif

    // Shrunken geometry: 15 x 11, 165 cycles per frame.
    localparam int unsigned SHV = 8, SHFP = 2, SHS = 3, SHBP = 2;
    localparam int unsigned SVV = 6, SVFP = 1, SVS = 2, SVBP = 2;
    localparam int unsigned SFrame = (SHV + SHFP + SHS + SHBP) * (SVV + SVFP + SVS + SVBP);
    localparam int unsigned MaxFails = 40;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] dx, dy, sdx, sdy;
    logic       bl, hs, vs, fs, sbl, shs, svs, sfs;
    logic [7:0] fc, sfc;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned edges = 0;
    int unsigned cyc   = 0;
    obs_t        exp_q[$];
    obs_t        exp_s_q[$];

    always #20 vga_clk = ~vga_clk;

    vga_timing_gen dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (dx),
        .DrawY       (dy),
        .blank       (bl),
        .hs          (hs),
        .vs          (vs),
        .frame_start (fs),
        .frame_cnt   (fc)
    );

    vga_timing_gen #(
        .H_VISIBLE (SHV), .H_FP (SHFP), .H_SYNC (SHS), .H_BP (SHBP),
        .V_VISIBLE (SVV), .V_FP (SVFP), .V_SYNC (SVS), .V_BP (SVBP)
    ) dut_s (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (sdx),
        .DrawY       (sdy),
        .blank       (sbl),
        .hs          (shs),
        .vs          (svs),
        .frame_start (sfs),
        .frame_cnt   (sfc)
    );

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    task automatic note_fail();
        fails++;
        if (fails >= MaxFails) finish_tb();
    endtask

    task automatic check_obs(input string name, input obs_t a, input obs_t e);
        tests++;
        if (a !== e) begin
            $display("FAIL %s @cyc %0d: got x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d, expected x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d",
                     name, cyc, a.x, a.y, a.blank, a.hs, a.vs, a.fs, a.fc,
                     e.x, e.y, e.blank, e.hs, e.vs, e.fs, e.fc);
            note_fail();
        end
    endtask

    task automatic check_int(input string name, input int unsigned act, input int unsigned req);
        tests++;
        if (act != req) begin
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, req);
            note_fail();
        end
    endtask

    // Raster position as a pure function of cycles elapsed since reset release.
    function automatic obs_t model(input bit in_rst, input int unsigned n,
                                   input int unsigned hv, input int unsigned hfp,
                                   input int unsigned hsw, input int unsigned hbp,
                                   input int unsigned vv, input int unsigned vfp,
                                   input int unsigned vsw, input int unsigned vbp);
        int unsigned ht, vt, frame, p, x, y;
        obs_t o;
        ht    = hv + hfp + hsw + hbp;
        vt    = vv + vfp + vsw + vbp;
        frame = ht * vt;
        if (in_rst) begin
            o = '{x: 10'(ht - 1), y: 10'(vt - 1), blank: 1'b0, hs: 1'b1, vs: 1'b1,
                  fs: 1'b0, fc: 8'd0};
            return o;
        end
        p       = n % frame;
        x       = p % ht;
        y       = p / ht;
        o.x     = 10'(x);
        o.y     = 10'(y);
        o.blank = (x < hv) && (y < vv);
        o.hs    = !((x >= hv + hfp) && (x < hv + hfp + hsw));
        o.vs    = !((y >= vv + vfp) && (y < vv + vfp + vsw));
        o.fs    = (p == 0);
        // frame_start cycles strictly before cycle n
        o.fc    = FcEn ? 8'(((n + frame - 1) / frame) % 256) : 8'd0;
        return o;
    endfunction

    // One cycle of stimulus: drive reset_n just after the edge and queue the expectation.
    task automatic step(input bit rst_val);
        bit          in_rst;
        int unsigned n;
        @(posedge vga_clk);
        if (reset_n) edges++;
        #1;
        reset_n = rst_val;
        if (!rst_val) edges = 0;
        in_rst = !reset_n || (edges == 0);
        n      = (edges == 0) ? 0 : edges - 1;
        exp_q.push_back(model(in_rst, n, 640, 16, 96, 48, 480, 10, 2, 33));
        exp_s_q.push_back(model(in_rst, n, SHV, SHFP, SHS, SHBP, SVV, SVFP, SVS, SVBP));
    endtask

    // Scoreboard monitor: one observation per cycle, sampled mid-cycle.
    always @(negedge vga_clk) begin
        obs_t a;
        cyc++;
        if (exp_q.size() != 0) begin
            a = {dx, dy, bl, hs, vs, fs, fc};
            check_obs("full", a, exp_q.pop_front());
        end
        if (exp_s_q.size() != 0) begin
            a = {sdx, sdy, sbl, shs, svs, sfs, sfc};
            check_obs("small", a, exp_s_q.pop_front());
        end
    end

    // Pulse-shape checks: full hs width, small vs width, small frame_start period.
    int unsigned hs_run = 0;
    int unsigned vs_run = 0;
    int unsigned last_fs = 0;
    bit          have_fs = 1'b0;
    always @(negedge vga_clk) begin
        if (!reset_n) begin
            hs_run  = 0;
            vs_run  = 0;
            have_fs = 1'b0;
        end else begin
            if (!hs) begin
                hs_run++;
            end else if (hs_run != 0) begin
                check_int("hs_width", hs_run, 96);
                hs_run = 0;
            end
            if (!svs) begin
                vs_run++;
            end else if (vs_run != 0) begin
                check_int("vs_width_small", vs_run, SVS * (SHV + SHFP + SHS + SHBP));
                vs_run = 0;
            end
            if (sfs) begin
                if (have_fs) check_int("fs_period_small", cyc - last_fs, SFrame);
                last_fs = cyc;
                have_fs = 1'b1;
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) step(1'b0);
        // Release, run into line 3 of the full raster, then reset asynchronously mid-line.
        repeat (2701) step(1'b1);
        repeat (2) step(1'b0);
        // Long run: many small frames, past the 256th frame_start.
        repeat (270 * SFrame + 5) step(1'b1);
        // Random reset placement and run lengths.
        for (int seg = 0; seg < 8; seg++) begin
            repeat ($urandom_range(3, 1)) step(1'b0);
            repeat ($urandom_range(2500, 40)) step(1'b1);
        end
        repeat (4) @(posedge vga_clk);
        check_int("drain_full", exp_q.size(), 0);
        check_int("drain_small", exp_s_q.size(), 0);
        finish_tb();
    end

endmodule
